// File: rtl/jtag_shift_master.sv
// JTAG initiator: shifts up to MAX_BITS TMS/TDI pairs out on a divided TCK,
// captures TDO per bit, and mirrors the target TAP state for debug.
module jtag_shift_master #(
  parameter int MAX_BITS = 32,
  parameter int CLK_DIV  = 2,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [MAX_BITS-1:0] cmd_tms_i,
  input  logic [MAX_BITS-1:0] cmd_tdi_i,
  output logic                rsp_valid_o,
  output logic [MAX_BITS-1:0] rsp_tdo_o,
  output logic                busy_o,
  output logic [3:0]          tap_state_o,
  output logic                tck_pad_o,
  output logic                tms_pad_o,
  output logic                tdi_pad_o,
  input  logic                tdo_pad_i
);

  // Command handshake: a command transfers in any cycle where cmd_valid_i and
  // cmd_ready_o are both high; inputs are sampled only in that cycle.

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_e;

  typedef enum logic [3:0] {
    TAP_TLR   = 4'd0,  TAP_RTI   = 4'd1,  TAP_SELDR = 4'd2,  TAP_CAPDR = 4'd3,
    TAP_SHDR  = 4'd4,  TAP_EX1DR = 4'd5,  TAP_PAUDR = 4'd6,  TAP_EX2DR = 4'd7,
    TAP_UPDDR = 4'd8,  TAP_SELIR = 4'd9,  TAP_CAPIR = 4'd10, TAP_SHIR  = 4'd11,
    TAP_EX1IR = 4'd12, TAP_PAUIR = 4'd13, TAP_EX2IR = 4'd14, TAP_UPDIR = 4'd15
  } tap_e;

  localparam int                 DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_BITS);

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    tap_e n;
    case (s)
      TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR: n = tms ? TAP_UPDDR : TAP_PAUDR;
      TAP_PAUDR: n = tms ? TAP_EX2DR : TAP_PAUDR;
      TAP_EX2DR: n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR: n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR: n = tms ? TAP_UPDIR : TAP_PAUIR;
      TAP_PAUIR: n = tms ? TAP_EX2IR : TAP_PAUIR;
      TAP_EX2IR: n = tms ? TAP_UPDIR : TAP_SHIR;
      default:   n = tms ? TAP_SELDR : TAP_RTI;
    endcase
    return n;
  endfunction

  state_e              state_q, state_d;
  tap_e                tap_q, tap_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [MAX_BITS-1:0] mask_q, mask_d;
  logic [MAX_BITS-1:0] tms_sh_q, tms_sh_d;
  logic [MAX_BITS-1:0] tdi_sh_q, tdi_sh_d;
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic [MAX_BITS-1:0] rsp_tdo_q, rsp_tdo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                tck_q, tck_d;
  logic                tms_pad_q, tms_pad_d;
  logic                tdi_pad_q, tdi_pad_d;

  logic                accept;
  logic [LEN_W-1:0]    len_c;
  logic [MAX_BITS-1:0] cap_next;

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    div_d       = div_q;
    rem_d       = rem_q;
    mask_d      = mask_q;
    tms_sh_d    = tms_sh_q;
    tdi_sh_d    = tdi_sh_q;
    cap_d       = cap_q;
    rsp_tdo_d   = rsp_tdo_q;
    rsp_valid_d = 1'b0;
    busy_d      = busy_q;
    ready_d     = ready_q;
    tck_d       = tck_q;
    tms_pad_d   = tms_pad_q;
    tdi_pad_d   = tdi_pad_q;
    accept      = cmd_valid_i & ready_q;
    len_c       = (cmd_len_i > LEN_MAX) ? LEN_MAX : cmd_len_i;
    cap_next    = tdo_pad_i ? (cap_q | mask_q) : cap_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          cap_d  = '0;
          div_d  = '0;
          mask_d = MAX_BITS'(1);
          if (len_c == '0) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_tdo_d   = '0;
          end else begin
            state_d   = ST_LOW;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
            rem_d     = len_c;
            tms_pad_d = cmd_tms_i[0];
            tdi_pad_d = cmd_tdi_i[0];
            tms_sh_d  = cmd_tms_i >> 1;
            tdi_sh_d  = cmd_tdi_i >> 1;
          end
        end
      end
      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_HIGH;
          tck_d   = 1'b1;
          // The target TAP moves on this rising edge with the TMS already on the pad.
          tap_d   = tap_next(tap_q, tms_pad_q);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          tck_d  = 1'b0;
          rem_d  = rem_q - LEN_W'(1);
          mask_d = mask_q << 1;
          if (rem_q == LEN_W'(1)) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_tdo_d   = cap_next;
            busy_d      = 1'b0;
            ready_d     = 1'b1;
          end else begin
            state_d   = ST_LOW;
            cap_d     = cap_next;
            tms_pad_d = tms_sh_q[0];
            tdi_pad_d = tdi_sh_q[0];
            tms_sh_d  = tms_sh_q >> 1;
            tdi_sh_d  = tdi_sh_q >> 1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tap_q       <= TAP_TLR;
      div_q       <= '0;
      rem_q       <= '0;
      mask_q      <= '0;
      tms_sh_q    <= '0;
      tdi_sh_q    <= '0;
      cap_q       <= '0;
      rsp_tdo_q   <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      tck_q       <= 1'b0;
      tms_pad_q   <= 1'b1;
      tdi_pad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      mask_q      <= mask_d;
      tms_sh_q    <= tms_sh_d;
      tdi_sh_q    <= tdi_sh_d;
      cap_q       <= cap_d;
      rsp_tdo_q   <= rsp_tdo_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      tck_q       <= tck_d;
      tms_pad_q   <= tms_pad_d;
      tdi_pad_q   <= tdi_pad_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tdo_o   = rsp_tdo_q;
  assign tap_state_o = tap_q;
  assign tck_pad_o   = tck_q;
  assign tms_pad_o   = tms_pad_q;
  assign tdi_pad_o   = tdi_pad_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: cycle-by-cycle pad/handshake checks against a
// timing model derived from bit index and half-period, plus a TAP table model.
module tb_jtag_shift_master;

  localparam int MAX_BITS = 32;
  localparam int CLK_DIV  = 2;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);
  localparam int H        = CLK_DIV;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                cmd_valid_i = 1'b0;
  logic                cmd_ready_o;
  logic [LEN_W-1:0]    cmd_len_i = '0;
  logic [MAX_BITS-1:0] cmd_tms_i = '0;
  logic [MAX_BITS-1:0] cmd_tdi_i = '0;
  logic                rsp_valid_o;
  logic [MAX_BITS-1:0] rsp_tdo_o;
  logic                busy_o;
  logic [3:0]          tap_state_o;
  logic                tck_pad_o;
  logic                tms_pad_o;
  logic                tdi_pad_o;
  logic                tdo_pad_i = 1'b0;

  jtag_shift_master #(.MAX_BITS(MAX_BITS), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tdo_o(rsp_tdo_o), .busy_o(busy_o),
    .tap_state_o(tap_state_o), .tck_pad_o(tck_pad_o), .tms_pad_o(tms_pad_o),
    .tdi_pad_o(tdi_pad_o), .tdo_pad_i(tdo_pad_i)
  );

  // Clock / cycle counter
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // IEEE 1149.1 next-state tables, indexed by current state, one per TMS value
  int tap_if0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int tap_if1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  int                vectors = 0;
  int                miscompares = 0;
  int                exp_tap = 0;
  logic              exp_tms = 1'b1;
  logic              exp_tdi = 1'b0;
  logic [31:0]       exp_rsp = '0;
  logic              tdo_hist[0:511];
  int                last_done_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_tck"}, 32'(tck_pad_o), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_tap"}, 32'(tap_state_o), 32'(exp_tap));
    chk({tag, "_tms"}, 32'(tms_pad_o), 32'(exp_tms));
    chk({tag, "_tdi"}, 32'(tdi_pad_o), 32'(exp_tdi));
    chk({tag, "_rsp_tdo"}, rsp_tdo_o, exp_rsp);
  endtask

  // Driver: idle cycles with the command interface quiet
  task automatic idle(input int n);
    cmd_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
      tdo_pad_i = 1'($urandom_range(0, 1));
      check_quiet("idle");
    end
  endtask

  // Driver + model: issue one command from the current cycle (idle or DONE) and
  // check every cycle up to and including its DONE cycle. abort_at>0 pulses
  // reset in that cycle after accept and checks the aborted state instead.
  task automatic run_cmd(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                         input bit loopback, input bit hold_valid, input int abort_at);
    int eff, done_t, k, b, hi;
    logic [31:0] cap;
    eff    = (len > MAX_BITS) ? MAX_BITS : len;
    done_t = 1 + 2 * eff * H;
    chk("ready_at_accept", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_len_i   = LEN_W'(len);
    cmd_tms_i   = tms;
    cmd_tdi_i   = tdi;
    @(posedge clk_i); #1;
    if (!hold_valid) cmd_valid_i = 1'b0;
    for (int t = 1; t <= done_t; t++) begin
      tdo_pad_i   = loopback ? tdi_pad_o : 1'($urandom_range(0, 1));
      tdo_hist[t] = tdo_pad_i;
      if (t < done_t) begin
        k  = (t - 1) / H;
        b  = k / 2;
        hi = k % 2;
        if (hi == 1 && ((t - 1) % H) == 0)
          exp_tap = tms[b] ? tap_if1[exp_tap] : tap_if0[exp_tap];
        exp_tms = tms[b];
        exp_tdi = tdi[b];
        chk("tck", 32'(tck_pad_o), 32'(hi));
        chk("tms", 32'(tms_pad_o), 32'(exp_tms));
        chk("tdi", 32'(tdi_pad_o), 32'(exp_tdi));
        chk("busy", 32'(busy_o), 32'd1);
        chk("ready_busy", 32'(cmd_ready_o), 32'd0);
        chk("rsp_valid_early", 32'(rsp_valid_o), 32'd0);
        chk("tap", 32'(tap_state_o), 32'(exp_tap));
        chk("rsp_tdo_held", rsp_tdo_o, exp_rsp);
      end else begin
        cap = '0;
        for (int i = 0; i < eff; i++) cap[i] = tdo_hist[2 * H * (i + 1)];
        exp_rsp = cap;
        last_done_cyc = cyc;
        chk("done_tck", 32'(tck_pad_o), 32'd0);
        chk("done_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("done_busy", 32'(busy_o), 32'd0);
        chk("done_ready", 32'(cmd_ready_o), 32'd1);
        chk("done_rsp_tdo", rsp_tdo_o, exp_rsp);
        chk("done_tap", 32'(tap_state_o), 32'(exp_tap));
        chk("done_tms", 32'(tms_pad_o), 32'(exp_tms));
        chk("done_tdi", 32'(tdi_pad_o), 32'(exp_tdi));
      end
      if (t == abort_at) begin
        rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i   = 1'b0;
        exp_tap = 0;
        exp_tms = 1'b1;
        exp_tdi = 1'b0;
        exp_rsp = '0;
        check_quiet("abort");
        return;
      end
      if (t < done_t) begin
        @(posedge clk_i); #1;
      end
    end
  endtask

  int t1, t2, rlen, gap;

  initial begin
    // Reset held two cycles
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_quiet("reset");
    rst_i = 1'b0;
    idle(3);

    // TAP navigation TLR -> SHIR
    run_cmd(5, 32'b00110, $urandom, 1'b0, 1'b0, 0);
    chk("nav_end_state", 32'(tap_state_o), 32'd11);
    idle(2);

    // Loopback shift of 0xA5 in SHIR
    run_cmd(8, 32'h0, 32'hA5, 1'b1, 1'b0, 0);
    chk("loopback_value", rsp_tdo_o, 32'h0000_00A5);
    idle(1);

    // Zero length and clamp above MAX_BITS
    run_cmd(0, $urandom, $urandom, 1'b0, 1'b0, 0);
    chk("zero_len_rsp", rsp_tdo_o, 32'h0);
    idle(1);
    run_cmd(40, $urandom, $urandom, 1'b0, 1'b0, 0);
    idle(2);

    // Back-to-back with cmd_valid_i held through the first command
    run_cmd(3, $urandom, $urandom, 1'b0, 1'b1, 0);
    t1 = last_done_cyc;
    run_cmd(3, $urandom, $urandom, 1'b0, 1'b0, 0);
    t2 = last_done_cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'(1 + 2 * 3 * H));
    idle(2);

    // Reset during the high phase of bit 4, then a normal command
    run_cmd(16, $urandom, $urandom, 1'b0, 1'b0, 1 + 8 * H + H);
    idle(1);
    run_cmd(5, 32'h1F, $urandom, 1'b0, 1'b0, 0);
    idle(1);

    // Randomized commands with random gaps (gap 0 = back-to-back)
    for (int n = 0; n < 24; n++) begin
      rlen = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_BITS + 1, 63)
                                         : $urandom_range(0, MAX_BITS);
      run_cmd(rlen, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
